// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port register file.
// Defaults match the RV32 integer register file.
package reg_file_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

  localparam int unsigned X0_IDX = 0;
  localparam reg_idx_t    X0_ADDR = reg_idx_t'(X0_IDX);

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register.
// A same-cycle issue beats a same-cycle writeback clear.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_valid,
  input  logic [AW-1:0]           set_reg,
  input  logic                    clr0_valid,
  input  logic [AW-1:0]           clr0_reg,
  input  logic                    clr1_valid,
  input  logic [AW-1:0]           clr1_reg,
  input  logic [NRD-1:0][AW-1:0]  lookup_reg,
  output logic [NRD-1:0]          lookup_busy,
  output logic [NREG-1:0]         busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr0_valid) busy_d[clr0_reg] = 1'b0;
    if (clr1_valid) busy_d[clr1_reg] = 1'b0;
    if (set_valid)  busy_d[set_reg]  = 1'b1;
    busy_d[AW'(X0_IDX)] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Lookups see this cycle's set/clear already applied.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      lookup_busy[i] = busy_d[lookup_reg[i]];
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NRD combinational reads with
// write-first bypass, two write ports (port 1 wins), busy scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD-1:0][AW-1:0]   read_reg,
  output logic [NRD-1:0][XLEN-1:0] read_data,
  output logic [NRD-1:0]           read_busy,
  input  logic                     write_enable0,
  input  logic [AW-1:0]            write_reg0,
  input  logic [XLEN-1:0]          write_data0,
  input  logic                     write_enable1,
  input  logic [AW-1:0]            write_reg1,
  input  logic [XLEN-1:0]          write_data1,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_reg,
  output logic [NREG-1:0]          busy_vec
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            commit0;
  logic            commit1;

  assign commit0 = write_enable0 && (write_reg0 != AW'(X0_IDX));
  assign commit1 = write_enable1 && (write_reg1 != AW'(X0_IDX));

  always_comb begin
    regs_d = regs_q;
    if (commit0) regs_d[write_reg0] = write_data0;
    if (commit1) regs_d[write_reg1] = write_data1;
    regs_d[X0_IDX] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // x0 is never committed, so regs_q[0] alone keeps it reading zero.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      read_data[i] = regs_q[read_reg[i]];
      if (commit0 && write_reg0 == read_reg[i])
        read_data[i] = write_data0;
      if (commit1 && write_reg1 == read_reg[i])
        read_data[i] = write_data1;
    end
  end

  reg_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_valid   (issue_valid),
    .set_reg     (issue_reg),
    .clr0_valid  (commit0),
    .clr0_reg    (write_reg0),
    .clr1_valid  (commit1),
    .clr1_reg    (write_reg1),
    .lookup_reg  (read_reg),
    .lookup_busy (read_busy),
    .busy_vec    (busy_vec)
  );

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32, data word width in bits.
REQ-002 Parameter NREG, default 32, register count; power of two, at least 2; AW = log2(NREG).
REQ-003 Parameter NRD, default 2, number of read ports, 1..4.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1, rising-edge clock for all state.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port read_reg, input, NRD x AW, read address per port.
REQ-008 Port read_data, output, NRD x XLEN, read data per port.
REQ-009 Port read_busy, output, NRD, scoreboard busy bit per read address.
REQ-010 Port write_enable0, input, 1, write port 0 enable.
REQ-011 Port write_reg0, input, AW, write port 0 address.
REQ-012 Port write_data0, input, XLEN, write port 0 data.
REQ-013 Ports write_enable1, write_reg1 and write_data1 SHALL match write port 0 in direction and width, for write port 1.
REQ-014 Port issue_valid, input, 1, marks a new pending producer this cycle.
REQ-015 Port issue_reg, input, AW, destination register of the pending producer.
REQ-016 Port busy_vec, output, NREG, full scoreboard state.

Function
REQ-017 Register 0 SHALL read as 0 on every port, never change on a write, and never be marked busy.
REQ-018 Writes SHALL commit on the rising edge of clk when the port's write_enable is 1 and its write_reg is nonzero.
REQ-019 If both write ports target the same register in one cycle, port 1 SHALL win.
REQ-020 Reads SHALL be combinational with zero-cycle latency.
REQ-021 A read matching an enabled write address in the same cycle SHALL return that write's data (write-first bypass), with port 1 data taking priority over port 0.
REQ-022 busy[r] SHALL be set on the clock edge when issue_valid is 1 and issue_reg equals r.
REQ-023 busy[r] SHALL be cleared on the clock edge when either write port commits to r.
REQ-024 If a set and a clear of busy[r] occur in the same cycle, the set SHALL win, because a new producer supersedes the completing one.
REQ-025 read_busy[i] SHALL be busy[read_reg[i]] after the set/clear update for this cycle is applied, so a same-cycle writeback reports not-busy unless a same-cycle issue re-sets it.
REQ-026 busy_vec SHALL reflect registered busy state only, without the same-cycle override.

Reset
REQ-027 While rst is 1 at a clock edge, all registers SHALL clear to 0 and all busy bits SHALL clear to 0.
REQ-028 Writes and issues in the same cycle as rst SHALL be ignored.
REQ-029 Combinational bypass SHALL remain active during rst; the data it returns is not guaranteed to persist after the reset edge.
REQ-030 After rst deasserts, every read SHALL return 0 with read_busy = 0 until the first write.

Structure
REQ-031 Package reg_file_pkg SHALL hold the default XLEN and NREG, the x0 address constant, and the register index typedef.
REQ-032 Busy tracking SHALL be implemented as sub-module reg_scoreboard (set/clear/lookup); data storage and bypass SHALL stay in reg_file_mp.

Verification
REQ-033 Reset, then write r1 = AAAAAAAA on port 0 -> read_reg = 1 returns AAAAAAAA in the same cycle (bypass) and on the following cycle.
REQ-034 Write r8 = FFFFFFFF on port 0 and r8 = 12345678 on port 1 in one cycle -> r8 reads 12345678 afterwards.
REQ-035 Write r0 = CCCCCCCC and issue r0 -> read_data for r0 is 0, busy_vec[0] = 0.
REQ-036 Issue r5, then 3 cycles later write r5 = 5 -> read_busy for r5 is 1 for 3 cycles, then 0 in the writeback cycle.
REQ-037 Issue r5 and write r5 in the same cycle -> busy_vec[5] = 1 on the next cycle.
REQ-038 Fill r1..r31 with nonzero data and mark several registers busy, then assert rst for one cycle -> all reads return 0 and busy_vec = 0.
